// File: rtl/debounce_multi.sv
// ----------------------------------------------------------------------------
// debounce_multi
//   N-channel push-button conditioner. Each channel has a two-flop input
//   synchroniser, a symmetric press/release debounce and a small IDLE/HELD/LONG
//   state machine. It produces a debounced level and one-cycle pulses for
//   press, release, long-press and auto-repeat. All outputs are registered.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous reset, active low
//   pb_i           raw asynchronous button inputs, active high
//   level_o        debounced button state
//   press_o        one-cycle pulse on accepted press
//   release_o      one-cycle pulse on accepted release
//   long_press_o   one-cycle pulse when hold time reaches LONG_PRESS_CYCLES
//   repeat_o       one-cycle pulse every REPEAT_CYCLES after long press
// ----------------------------------------------------------------------------
module debounce_multi #(
  parameter int unsigned N_CH              = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 3750000,
  parameter int unsigned LONG_PRESS_CYCLES = 125000000,
  parameter int unsigned REPEAT_CYCLES     = 25000000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N_CH-1:0] pb_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_press_o,
  output logic [N_CH-1:0] repeat_o
);

  localparam int unsigned STAB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ?
                                     LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HOLD_W   = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);

  // Repeat only makes sense once a long press can happen.
  localparam bit LONG_EN = (LONG_PRESS_CYCLES != 0);
  localparam bit REP_EN  = LONG_EN && (REPEAT_CYCLES != 0);

  localparam int unsigned LONG_LAST_I = LONG_EN ? LONG_PRESS_CYCLES - 1 : 0;
  localparam int unsigned REP_LAST_I  = REP_EN  ? REPEAT_CYCLES - 1     : 0;

  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_LAST_I);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REP_LAST_I);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } state_e;

  // Two-flop synchroniser; raw_s_q is the only view of the buttons used below.
  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] raw_s_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      raw_s_q <= '0;
    end else begin
      sync1_q <= pb_i;
      raw_s_q <= sync1_q;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_e            state_q, state_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              rel_q, rel_d;
    logic              long_q, long_d;
    logic              rep_q, rep_d;

    // State, counters and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        stab_q  <= '0;
        hold_q  <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        stab_q  <= stab_d;
        hold_q  <= hold_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
        rep_q   <= rep_d;
      end
    end

    // Next-state, counter update and pulse generation.
    always_comb begin
      state_d = state_q;
      stab_d  = stab_q;
      hold_d  = hold_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;
      rep_d   = 1'b0;

      unique case (state_q)
        IDLE: begin
          hold_d = '0;
          if (raw_s_q[c]) begin
            if (stab_q == STAB_LAST) begin
              state_d = HELD;
              level_d = 1'b1;
              press_d = 1'b1;
              stab_d  = '0;
            end else begin
              stab_d = stab_q + STAB_W'(1);
            end
          end else begin
            stab_d = '0;
          end
        end

        HELD, LONG: begin
          // Hold timing keeps running while a release is being qualified.
          if (state_q == HELD) begin
            if (LONG_EN) begin
              if (hold_q == LONG_LAST) begin
                state_d = LONG;
                long_d  = 1'b1;
                hold_d  = '0;
              end else begin
                hold_d = hold_q + HOLD_W'(1);
              end
            end else begin
              hold_d = '0;
            end
          end else begin
            if (REP_EN) begin
              if (hold_q == REP_LAST) begin
                rep_d  = 1'b1;
                hold_d = '0;
              end else begin
                hold_d = hold_q + HOLD_W'(1);
              end
            end else begin
              hold_d = '0;
            end
          end

          // Accepted release overrides any long/repeat event this cycle.
          if (!raw_s_q[c]) begin
            if (stab_q == STAB_LAST) begin
              state_d = IDLE;
              level_d = 1'b0;
              rel_d   = 1'b1;
              long_d  = 1'b0;
              rep_d   = 1'b0;
              stab_d  = '0;
              hold_d  = '0;
            end else begin
              stab_d = stab_q + STAB_W'(1);
            end
          end else begin
            stab_d = '0;
          end
        end

        default: begin
          state_d = IDLE;
          level_d = 1'b0;
          stab_d  = '0;
          hold_d  = '0;
        end
      endcase
    end

    assign level_o[c]      = level_q;
    assign press_o[c]      = press_q;
    assign release_o[c]    = rel_q;
    assign long_press_o[c] = long_q;
    assign repeat_o[c]     = rep_q;
  end

endmodule
